fifo_shadow_checker: RTL and testbench
======================================

// Module: fifo_shadow_checker
// PURPOSE
//  Synthesizable checker that consumes the same FIFO_Interface signals the bench monitor samples.
//  Holds a cycle-accurate shadow model of the sync FIFO, compares DUT outputs against it every
//  cycle, and counts passes/failures in hardware. Records the first failure.
//  Sits downstream of the interface, in parallel with the class scoreboard; also usable in emulation.
// PARAMETERS
//  FIFO_WIDTH   16  data width of data_in/data_out
//  FIFO_DEPTH   8   entries; power of 2, >=4
//  CNT_W        16  width of pass/error counters (saturating)
//  STOP_ON_ERR  0   1: go to HALTED on first mismatch
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst_n        in   1           synchronous active-low reset (shared with DUT)
//  chk_en       in   1           1: checking enabled
//  wr_en        in   1           observed DUT write request
//  rd_en        in   1           observed DUT read request
//  data_in      in   FIFO_WIDTH  observed write data
//  data_out     in   FIFO_WIDTH  observed DUT read data
//  wr_ack, overflow, underflow                in 1 each  observed DUT registered flags
//  full, empty, almostfull, almostempty       in 1 each  observed DUT status flags
//  err_pulse    out  1           1-cycle pulse per cycle containing any mismatch
//  err_vec      out  8           per-signal mismatch of that cycle [0]data_out [1]wr_ack
//                                [2]overflow [3]underflow [4]full [5]empty [6]almostfull [7]almostempty
//  pass_count   out  CNT_W       compared cycles with no mismatch
//  err_count    out  CNT_W       compared cycles with >=1 mismatch
//  first_err_vec    out 8        err_vec of first failing cycle, held
//  first_err_cycle  out 32       cycle index (cycles since reset release) of first failure
//  halted       out  1           FSM in HALTED
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): shadow count/pointers=0; all outputs 0; FSM->ARMED.
//  - FSM: ARMED -(1 cycle)-> CHECK. CHECK -(mismatch & STOP_ON_ERR)-> HALTED. HALTED held until reset.
//    ARMED skips compare (DUT registered flags settling out of reset). chk_en=0: no compare,
//    no counting, shadow still tracks.
//  - Shadow update each posedge (rst_n=1) from sampled wr_en/rd_en/data_in:
//    wr_ok = wr_en & ~full_s; rd_ok = rd_en & ~empty_s; both on same edge: both occur and count unchanged.
//    Empty + both requests: write only. Full + both requests: read only.
//    Pointers wrap modulo FIFO_DEPTH. count width = $clog2(FIFO_DEPTH)+1.
//    Registered expectations: wr_ack_s=wr_ok; overflow_s=wr_en&full_s;
//    underflow_s=rd_en&empty_s; data_out_s=mem[rd_ptr] when rd_ok, else held.
//  - Combinational expectations from count_s:
//    full_s=(count==DEPTH); empty_s=(count==0); almostfull_s=(count==DEPTH-1); almostempty_s=(count==1).
//  - Compare, in CHECK with chk_en=1: each posedge compares DUT vs shadow values of the cycle just
//    ended. data_out is compared only if the previous cycle had rd_ok; otherwise err_vec[0]=0.
//  - Result latency: err_pulse/err_vec/counters update 1 cycle after the mismatched cycle.
//  - Counters saturate at all-ones, no wrap. first_err_* is written only when err_count goes 0->1.
//  - Cycle index: 32-bit, resets to 0, increments every cycle after reset release, saturates.
//  - Reset mid-operation: shadow and all state clear on that edge; in-flight data discarded.
// TESTING
//  1 Reset, write 8 words 0x0001..0x0008 -> full=1 after 8th;
//    err_count=0, pass_count increments once per cycle.
//  2 Full, wr_en=1 for 1 cycle -> overflow expected=1; DUT matches -> no err_pulse.
//    Force DUT overflow=0 -> err_vec=8'h04, err_count=1.
//  3 Empty, rd_en=1 -> underflow expected=1.
//    Force DUT data_out corrupted after a valid read -> err_vec[0]=1 next cycle.
//  4 count=4, wr_en=rd_en=1 for 10 cycles -> count stays 4; pointers wrap; zero errors.
//  5 STOP_ON_ERR=1, inject a wrong almostfull -> halted=1; counters frozen;
//    first_err_vec=8'h40; first_err_cycle equals the injection cycle.
//  6 Assert rst_n=0 mid-burst with count=5 -> all outputs 0;
//    ARMED then CHECK; refill checks cleanly.

Source files
------------

// File: rtl/fifo_shadow_checker.sv
// Shadow-model checker for a synchronous FIFO: mirrors the FIFO from its observed requests,
// compares the observed outputs every cycle and keeps pass/error statistics plus the first failure.
module fifo_shadow_checker #(
  parameter int FIFO_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chk_en,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  output logic                  err_pulse,
  output logic [7:0]            err_vec,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [7:0]            first_err_vec,
  output logic [31:0]           first_err_cycle,
  output logic                  halted,
  output logic [1:0]            state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_SW = PTR_W + 1;

  typedef enum logic [1:0] {ST_ARMED = 2'd0, ST_CHECK = 2'd1, ST_HALTED = 2'd2} state_t;

  state_t                  state, state_nx;
  logic                    compare_en;
  logic [FIFO_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_SW-1:0]       count_s;
  logic                    wr_ack_s, overflow_s, underflow_s, rd_ok_q;
  logic [FIFO_WIDTH-1:0]   data_out_s;
  logic                    full_s, empty_s, almostfull_s, almostempty_s;
  logic                    wr_ok, rd_ok;
  logic [7:0]              cmp_vec;
  logic [31:0]             cycle_cnt;

  assign full_s        = (count_s == CNT_SW'(FIFO_DEPTH));
  assign empty_s       = (count_s == '0);
  assign almostfull_s  = (count_s == CNT_SW'(FIFO_DEPTH - 1));
  assign almostempty_s = (count_s == CNT_SW'(1));
  assign wr_ok         = wr_en & ~full_s;
  assign rd_ok         = rd_en & ~empty_s;

  // Shadow storage is not reset: stale entries are never read because count_s gates rd_ok.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_s     <= '0;
      wr_ack_s    <= 1'b0;
      overflow_s  <= 1'b0;
      underflow_s <= 1'b0;
      data_out_s  <= '0;
      rd_ok_q     <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        data_out_s <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_s <= count_s + CNT_SW'(1);
        2'b01:   count_s <= count_s - CNT_SW'(1);
        default: count_s <= count_s;
      endcase
      wr_ack_s    <= wr_ok;
      overflow_s  <= wr_en & full_s;
      underflow_s <= rd_en & empty_s;
      rd_ok_q     <= rd_ok;
    end
  end

  // data_out only carries meaning in the cycle right after an accepted read.
  always_comb begin
    cmp_vec    = '0;
    cmp_vec[0] = rd_ok_q & (data_out != data_out_s);
    cmp_vec[1] = (wr_ack != wr_ack_s);
    cmp_vec[2] = (overflow != overflow_s);
    cmp_vec[3] = (underflow != underflow_s);
    cmp_vec[4] = (full != full_s);
    cmp_vec[5] = (empty != empty_s);
    cmp_vec[6] = (almostfull != almostfull_s);
    cmp_vec[7] = (almostempty != almostempty_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_ARMED;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_ARMED:  state_nx = ST_CHECK;
      ST_CHECK:  if (compare_en && (|cmp_vec) && (STOP_ON_ERR != 0)) state_nx = ST_HALTED;
      ST_HALTED: state_nx = ST_HALTED;
      default:   state_nx = ST_ARMED;
    endcase
  end

  always_comb begin
    compare_en = (state == ST_CHECK) && chk_en;
    halted     = (state == ST_HALTED);
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse       <= 1'b0;
      err_vec         <= '0;
      pass_count      <= '0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_cycle <= '0;
      cycle_cnt       <= '0;
    end else begin
      err_pulse <= 1'b0;
      err_vec   <= '0;
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
      if (compare_en) begin
        err_vec <= cmp_vec;
        if (|cmp_vec) begin
          err_pulse <= 1'b1;
          if (err_count == '0) begin
            first_err_vec   <= cmp_vec;
            first_err_cycle <= cycle_cnt;
          end
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
        end else if (pass_count != '1) begin
          pass_count <= pass_count + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_shadow_checker.sv
// Bench for fifo_shadow_checker: plays the observed FIFO from a queue model, plants faults
// on chosen cycles and predicts the checker's statistics for a free-running and a stop-on-error copy.
module tb_fifo_shadow_checker;
  logic        clk = 1'b0;
  logic        rst_n, chk_en, wr_en, rd_en;
  logic [15:0] data_in, data_out;
  logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;

  logic        a_err_pulse, a_halted, b_err_pulse, b_halted;
  logic [7:0]  a_err_vec, a_first_err_vec, b_err_vec, b_first_err_vec;
  logic [15:0] a_pass_count, a_err_count;
  logic [3:0]  b_pass_count, b_err_count;
  logic [31:0] a_first_err_cycle, b_first_err_cycle;
  logic [1:0]  a_state_dbg, b_state_dbg;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  fifo_shadow_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(16), .STOP_ON_ERR(0)) u_a (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .err_pulse(a_err_pulse), .err_vec(a_err_vec),
    .pass_count(a_pass_count), .err_count(a_err_count), .first_err_vec(a_first_err_vec),
    .first_err_cycle(a_first_err_cycle), .halted(a_halted), .state_dbg(a_state_dbg)
  );

  fifo_shadow_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_W(4), .STOP_ON_ERR(1)) u_b (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .err_pulse(b_err_pulse), .err_vec(b_err_vec),
    .pass_count(b_pass_count), .err_count(b_err_count), .first_err_vec(b_first_err_vec),
    .first_err_cycle(b_first_err_cycle), .halted(b_halted), .state_dbg(b_state_dbg)
  );

  // Observed-FIFO model
  logic [15:0] q[$];
  logic        m_wr_ack, m_ovf, m_udf, last_rd_ok, armed;
  logic [15:0] m_dout;
  int unsigned cyc;

  // Scoreboard: expected checker outputs, index 0 = free-running, 1 = stop-on-error
  int unsigned e_pass [2];
  int unsigned e_err  [2];
  int unsigned e_fcyc [2];
  logic [7:0]  e_fvec [2];
  logic [7:0]  e_vec  [2];
  logic        e_pulse[2];
  logic        e_halt [2];
  int unsigned cmax   [2] = '{32'd65535, 32'd15};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("a_pulse", 32'(a_err_pulse), 32'(e_pulse[0]));
    check_eq("a_vec",   32'(a_err_vec),   32'(e_vec[0]));
    check_eq("a_pass",  32'(a_pass_count), e_pass[0]);
    check_eq("a_err",   32'(a_err_count),  e_err[0]);
    check_eq("a_fvec",  32'(a_first_err_vec), 32'(e_fvec[0]));
    check_eq("a_fcyc",  a_first_err_cycle, e_fcyc[0]);
    check_eq("a_halt",  32'(a_halted), 32'(e_halt[0]));
    check_eq("b_pulse", 32'(b_err_pulse), 32'(e_pulse[1]));
    check_eq("b_vec",   32'(b_err_vec),   32'(e_vec[1]));
    check_eq("b_pass",  32'(b_pass_count), e_pass[1]);
    check_eq("b_err",   32'(b_err_count),  e_err[1]);
    check_eq("b_fvec",  32'(b_first_err_vec), 32'(e_fvec[1]));
    check_eq("b_fcyc",  b_first_err_cycle, e_fcyc[1]);
    check_eq("b_halt",  32'(b_halted), 32'(e_halt[1]));
  endtask

  // Drive observed FIFO outputs for the current state, with faults XORed in by inj.
  task automatic drive_fifo(input logic [7:0] inj);
    int sz;
    sz = q.size();
    data_out    = m_dout ^ (inj[0] ? 16'hA5A5 : 16'h0000);
    wr_ack      = m_wr_ack ^ inj[1];
    overflow    = m_ovf ^ inj[2];
    underflow   = m_udf ^ inj[3];
    full        = (sz == 8) ^ inj[4];
    empty       = (sz == 0) ^ inj[5];
    almostfull  = (sz == 7) ^ inj[6];
    almostempty = (sz == 1) ^ inj[7];
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    q.delete();
    m_wr_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    drive_fifo(8'h00);
    for (int i = 0; i < 2; i++) begin
      e_pass[i] = 0; e_err[i] = 0; e_fcyc[i] = 0; e_fvec[i] = '0;
      e_vec[i] = '0; e_pulse[i] = 1'b0; e_halt[i] = 1'b0;
    end
    @(posedge clk);
    #1 check_outputs();
    last_rd_ok = 1'b0; armed = 1'b1; cyc = 0;
    rst_n = 1'b1;
  endtask

  // Driver: one cycle of requests plus planted faults, then model update and compare.
  task automatic step(input logic wr, input logic rd, input logic [15:0] din, input logic [7:0] inj);
    logic [7:0] want;
    logic       wr_ok, rd_ok;
    int         sz;
    sz = q.size();
    wr_en = wr; rd_en = rd; data_in = din;
    drive_fifo(inj);
    want = {inj[7:1], inj[0] & last_rd_ok};
    for (int i = 0; i < 2; i++) begin
      e_pulse[i] = 1'b0;
      e_vec[i]   = '0;
      if (!armed && chk_en && !e_halt[i]) begin
        e_vec[i] = want;
        if (want != '0) begin
          e_pulse[i] = 1'b1;
          if (e_err[i] == 0) begin
            e_fvec[i] = want;
            e_fcyc[i] = cyc;
          end
          if (e_err[i] < cmax[i]) e_err[i]++;
          if (i == 1) e_halt[i] = 1'b1;
        end else if (e_pass[i] < cmax[i]) begin
          e_pass[i]++;
        end
      end
    end
    @(posedge clk);
    wr_ok    = wr && (sz < 8);
    rd_ok    = rd && (sz > 0);
    m_wr_ack = wr_ok;
    m_ovf    = wr && (sz == 8);
    m_udf    = rd && (sz == 0);
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    last_rd_ok = rd_ok;
    armed = 1'b0;
    cyc++;
    #1 check_outputs();
  endtask

  initial begin
    logic [7:0] inj;
    chk_en = 1'b1;
    do_reset();

    // Fill 1..8; the idle cycle after the 8th write checks full
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i), 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    check_eq("t1_pass8", 32'(a_pass_count), 32'd8);
    check_eq("t1_err0", 32'(a_err_count), 32'd0);

    // Overflow matched, then overflow forced low
    step(1'b1, 1'b0, 16'h00FF, 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    check_eq("t2_nopulse", 32'(a_err_pulse), 32'd0);
    step(1'b1, 1'b0, 16'h00FE, 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h04);
    check_eq("t2_vec04", 32'(a_err_vec), 32'h04);
    check_eq("t2_err1", 32'(a_err_count), 32'd1);
    check_eq("t2_b_halt", 32'(b_halted), 32'd1);

    // Drain, underflow, then corrupted data after a real read vs. after no read
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000, 8'h00);
    step(1'b0, 1'b1, 16'h0000, 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    step(1'b1, 1'b0, 16'h1234, 8'h00);
    step(1'b0, 1'b1, 16'h0000, 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h01);
    check_eq("t3_vec01", 32'(a_err_vec), 32'h01);
    step(1'b0, 1'b0, 16'h0000, 8'h01);
    check_eq("t3_noread", 32'(a_err_vec), 32'h00);

    // Count held at 4 under simultaneous read/write, pointers wrap
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'($urandom), 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16'($urandom), 8'h00);
    check_eq("t4_err0", 32'(a_err_count), 32'd0);

    // Checking disabled: faults ignored, shadow keeps tracking
    chk_en = 1'b0;
    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 8'h01 << $urandom_range(0, 7));
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 8'h00);

    // Stop-on-error: wrong almostfull at count 7
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'($urandom), 8'h00);
    step(1'b0, 1'b0, 16'h0000, 8'h40);
    check_eq("t5_halt", 32'(b_halted), 32'd1);
    check_eq("t5_fvec", 32'(b_first_err_vec), 32'h40);
    check_eq("t5_fcyc", b_first_err_cycle, 32'd7);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'($urandom), 8'h02);
    check_eq("t5_frozen", 32'(b_err_count), 32'd1);

    // Reset mid-burst at count 5; fault in the ARMED cycle is not counted
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'($urandom), 8'h00);
    wr_en = 1'b1;
    do_reset();
    check_eq("t6_pass0", 32'(a_pass_count), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 8'h02);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'($urandom), 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'($urandom), 8'h00);
    check_eq("t6_err0", 32'(a_err_count), 32'd0);

    // Clean random traffic saturates the narrow pass counter, then random faults
    do_reset();
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 8'h00);
    check_eq("sat_pass", 32'(b_pass_count), 32'd15);
    for (int i = 0; i < 300; i++) begin
      inj = ($urandom_range(0, 19) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      chk_en = ($urandom_range(0, 9) != 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), inj);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
